// File: rtl/keyboard_writer_pkg.sv
// Shared constants for the PS/2 host-to-device transmitter.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package keyboard_writer_pkg;

  // Transmitter states, kept as plain constants so legacy tools can read them.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  // Eight data bits + odd parity + stop bit are shifted out after the start bit.
  localparam int FRAME_BITS = 10;
  // The device acknowledge is read on this falling clock edge.
  localparam int ACK_EDGE   = 11;

  // Frame as it leaves LSB first: data, odd parity, stop (always 1).
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/keyboard_writer_if.sv
// Host-side handshake of the PS/2 transmitter: command byte in, status out.
// Latency: wires only.
// Backpressure: start is dropped by the writer while busy is high.
interface keyboard_writer_if;
  logic       start;
  logic [7:0] txData;
  logic       busy;
  logic       done;
  logic       error;
  logic       rxInhibit;

  modport master (output start, txData, input busy, done, error, rxInhibit);
  modport slave  (input start, txData, output busy, done, error, rxInhibit);
endinterface

// File: rtl/keyboard_writer_ps2_line_sync.sv
// Brings the raw PS/2 clock/data lines into the fast domain and flags clock falls.
// Latency: 2 cycles to the synchronised level; fall pulse valid in the cycle after.
// Backpressure: none; free-running.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2ClkIn,
  input  logic ps2DataIn,
  output logic clkFall,
  output logic dataLevel
);

  logic clkMeta;
  logic clkSync;
  logic clkPrev;
  logic dataMeta;
  logic dataSync;

  // Two-stage synchronisers plus one history flop on clock; reset to the idle-high level
  // so leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkMeta  <= 1'b1;
      clkSync  <= 1'b1;
      clkPrev  <= 1'b1;
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      clkMeta  <= ps2ClkIn;
      clkSync  <= clkMeta;
      clkPrev  <= clkSync;
      dataMeta <= ps2DataIn;
      dataSync <= dataMeta;
    end
  end

  assign clkFall   = clkPrev & ~clkSync;
  assign dataLevel = dataSync;

endmodule

// File: rtl/keyboard_writer.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 bits out, ACK check.
// Latency: INHIBIT_CYCLES + 1 before release, then paced by 11 device clock falls.
// Backpressure: start ignored while busy; a stalled device is cut off after TIMEOUT_CYCLES.
module keyboard_writer
  import keyboard_writer_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic                clk,
  input  logic                rst,
  keyboard_writer_if.slave    host,
  input  logic                ps2ClkIn,
  input  logic                ps2DataIn,
  output logic                ps2ClkDrive,
  output logic                ps2DataDrive
);

  // One counter serves both the inhibit hold and the inter-edge timeout.
  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_FRAME_CNT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] ACK_CNT        = 4'(ACK_EDGE - 1);

  logic [2:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         bitCnt;
  logic [9:0]         frame;
  logic               clkFall;
  logic               dataLevel;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2ClkIn  (ps2ClkIn),
    .ps2DataIn (ps2DataIn),
    .clkFall   (clkFall),
    .dataLevel (dataLevel)
  );

  // Main sequencer; drives are registered so the open-drain lines never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      bitCnt       <= '0;
      frame        <= '0;
      ps2ClkDrive  <= 1'b0;
      ps2DataDrive <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ps2ClkDrive  <= 1'b0;
          ps2DataDrive <= 1'b0;
          if (host.start) begin
            frame       <= build_frame(host.txData);
            bitCnt      <= '0;
            timer       <= '0;
            ps2ClkDrive <= 1'b1;
            state       <= ST_INHIBIT;
          end
        end

        // Hold clock low long enough for the device to abandon any frame of its own.
        ST_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            ps2DataDrive <= 1'b1;
            state        <= ST_REQ;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Start bit is on the data line; releasing clock hands control to the device.
        ST_REQ: begin
          ps2ClkDrive <= 1'b0;
          timer       <= '0;
          bitCnt      <= '0;
          state       <= ST_SEND;
        end

        // Each device falling edge advances one bit; the 10th places the stop bit
        // (drive released) and the frame is then complete.
        ST_SEND: begin
          if (clkFall) begin
            ps2DataDrive <= ~frame[0];
            frame        <= {1'b0, frame[9:1]};
            bitCnt       <= bitCnt + 1'b1;
            timer        <= '0;
            if (bitCnt == LAST_FRAME_CNT) begin
              state <= ST_ACK;
            end
          end else if (timer == TIMEOUT_LAST) begin
            ps2DataDrive <= 1'b0;
            state        <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Device pulls data low before the final falling edge to acknowledge.
        ST_ACK: begin
          if (clkFall && (bitCnt == ACK_CNT)) begin
            bitCnt       <= bitCnt + 1'b1;
            ps2DataDrive <= 1'b0;
            state        <= dataLevel ? ST_ERROR : ST_DONE;
          end else if (timer == TIMEOUT_LAST) begin
            ps2DataDrive <= 1'b0;
            state        <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          ps2ClkDrive  <= 1'b0;
          ps2DataDrive <= 1'b0;
          state        <= ST_IDLE;
        end

        default: begin
          ps2ClkDrive  <= 1'b0;
          ps2DataDrive <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Status is a pure decode of the state register, so reset clears it immediately.
  assign host.busy      = (state != ST_IDLE);
  assign host.rxInhibit = (state != ST_IDLE);
  assign host.done      = (state == ST_DONE);
  assign host.error     = (state == ST_ERROR);

endmodule

// File: tb/tb_keyboard_writer.sv
// Bench for keyboard_writer: a PS/2 device model clocks frames out of the DUT and
// every received frame is compared with the frame computed from the byte alone.
// Line invariants are checked on every falling clk edge.
module tb_keyboard_writer;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int LOW  = 10;
  localparam int HIGH = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keyboard_writer_if kb_if ();

  logic ps2ClkIn, ps2DataIn, ps2ClkDrive, ps2DataDrive;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain wired-AND of host and device.
  assign ps2ClkIn  = dev_clk  & ~ps2ClkDrive;
  assign ps2DataIn = dev_data & ~ps2DataDrive;

  keyboard_writer #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (kb_if),
    .ps2ClkIn     (ps2ClkIn),
    .ps2DataIn    (ps2DataIn),
    .ps2ClkDrive  (ps2ClkDrive),
    .ps2DataDrive (ps2DataDrive)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: data LSB first, then a parity bit making the count of ones odd, then stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Per-cycle compare against the rules that hold at all times.
  always @(negedge clk) begin
    check("rxinhibit_eq_busy", kb_if.rxInhibit, kb_if.busy);
    check("done_error_exclusive", kb_if.done & kb_if.error, 0);
    if (!kb_if.busy) check("idle_lines_released", {ps2ClkDrive, ps2DataDrive}, 0);
    if (kb_if.done) done_cnt++;
    if (kb_if.error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // Device side: wait for request-to-send, then clock npulses; sample on rising edges.
  task automatic device_run(input int npulses, input logic ackbit, output logic [9:0] bits,
                            output int lat, output int last_fall);
    int w = 0;
    bits = '0;
    lat = -1;
    last_fall = 0;
    while (!(ps2ClkIn === 1'b1 && ps2DataIn === 1'b0) && w < INH + 100) begin
      @(negedge clk);
      w++;
    end
    check("request_to_send_seen", {ps2ClkIn, ps2DataIn}, 2'b10);
    if (!(ps2ClkIn === 1'b1 && ps2DataIn === 1'b0)) return;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= npulses; i++) begin
      if (i == 11) begin
        dev_data = ackbit;
        repeat (3) @(negedge clk);
      end
      dev_clk = 1'b0;
      last_fall = cyc;
      for (int c = 0; c < LOW; c++) begin
        @(negedge clk);
        if (i == 1 && lat < 0 && ps2DataDrive == 1'b0) lat = c + 1;
      end
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = ps2DataIn;
      repeat (HIGH) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic txn(input logic [7:0] d, input int npulses, input logic ackbit, input bit inject,
                     input bit wait_end, output logic [9:0] bits, output int lat,
                     output int inh, output int last_fall);
    int w;
    @(negedge clk);
    kb_if.start = 1'b1;
    kb_if.txData = d;
    @(negedge clk);
    kb_if.start = 1'b0;
    check("busy_after_start", kb_if.busy, 1);
    check("clk_drive_after_start", ps2ClkDrive, 1);
    inh = 0;
    while (ps2ClkDrive && !ps2DataDrive && inh < INH + 100) begin
      inh++;
      @(negedge clk);
    end
    fork
      device_run(npulses, ackbit, bits, lat, last_fall);
      begin
        if (inject) begin
          repeat (60) @(negedge clk);
          kb_if.start = 1'b1;
          kb_if.txData = ~d;
          @(negedge clk);
          kb_if.start = 1'b0;
        end
      end
    join
    if (wait_end) begin
      w = 0;
      while (kb_if.busy && w < TMO + 100) begin
        @(negedge clk);
        w++;
      end
      check("txn_completes", kb_if.busy, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    logic       ack;
    int lat, inh, lf, d0, e0;

    kb_if.start = 1'b0;
    kb_if.txData = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", kb_if.busy, 0);
    check("rst_done", kb_if.done, 0);
    check("rst_error", kb_if.error, 0);
    check("rst_rxinhibit", kb_if.rxInhibit, 0);
    check("rst_drives", {ps2ClkDrive, ps2DataDrive}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK low: hand-computed bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    d0 = done_cnt; e0 = err_cnt;
    txn(8'hED, 11, 1'b0, 1'b0, 1'b1, bits, lat, inh, lf);
    check("ed_data", bits[7:0], 8'b1110_1101);
    check("ed_parity", bits[8], 1);
    check("ed_stop", bits[9], 1);
    check("ed_model", bits, model_frame(8'hED));
    check("ed_data_latency", lat, 3);
    check("ed_done", done_cnt - d0, 1);
    check("ed_no_error", err_cnt - e0, 0);

    // 0xF4: parity 0, inhibit held long enough.
    d0 = done_cnt; e0 = err_cnt;
    txn(8'hF4, 11, 1'b0, 1'b0, 1'b1, bits, lat, inh, lf);
    check("f4_parity", bits[8], 0);
    check("f4_model", bits, model_frame(8'hF4));
    check("f4_inhibit_len", (inh >= INH), 1);
    check("f4_done", done_cnt - d0, 1);

    // NACK from device.
    d = 8'($urandom_range(0, 255));
    d0 = done_cnt; e0 = err_cnt;
    txn(d, 11, 1'b1, 1'b0, 1'b1, bits, lat, inh, lf);
    check("nack_model", bits, model_frame(d));
    check("nack_error", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);
    check("nack_drives", {ps2ClkDrive, ps2DataDrive}, 0);

    // Device stalls after bit 4: error TIMEOUT cycles after the edge is seen (3-cycle line path).
    d0 = done_cnt; e0 = err_cnt;
    txn(8'h5A, 4, 1'b0, 1'b0, 1'b1, bits, lat, inh, lf);
    check("timeout_error", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_delay", err_cyc - lf, TMO + 3);
    check("timeout_drives", {ps2ClkDrive, ps2DataDrive}, 0);

    // start mid-SEND must not disturb the frame or queue a second one.
    d = 8'($urandom_range(0, 255));
    d0 = done_cnt; e0 = err_cnt;
    txn(d, 11, 1'b0, 1'b1, 1'b1, bits, lat, inh, lf);
    check("busy_start_model", bits, model_frame(d));
    repeat (100) @(negedge clk);
    check("busy_start_idle", kb_if.busy, 0);
    check("busy_start_one_done", done_cnt - d0, 1);

    // Asynchronous reset in the middle of SEND.
    txn(8'hA5, 3, 1'b0, 1'b0, 1'b0, bits, lat, inh, lf);
    check("pre_reset_busy", kb_if.busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", kb_if.busy, 0);
    check("async_rst_flags", {kb_if.done, kb_if.error, kb_if.rxInhibit}, 0);
    check("async_rst_drives", {ps2ClkDrive, ps2DataDrive}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    txn(8'h01, 11, 1'b0, 1'b0, 1'b1, bits, lat, inh, lf);
    check("post_rst_parity", bits[8], 0);
    check("post_rst_model", bits, model_frame(8'h01));
    check("post_rst_done", done_cnt - d0, 1);

    // Randomised traffic with occasional NACKs.
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) == 0);
      d0 = done_cnt; e0 = err_cnt;
      txn(d, 11, ack, 1'b0, 1'b1, bits, lat, inh, lf);
      check("rand_model", bits, model_frame(d));
      check("rand_done", done_cnt - d0, ack ? 0 : 1);
      check("rand_error", err_cnt - e0, ack ? 1 : 0);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
